dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
Control and tag side of the 4-way, 128-bit-line data cache. It holds the tag/valid array and true-LRU state, detects read and write hits, and schedules the single memory port between line refills and write-through stores. It drives the hit-way, LRU-way, write-hit and read-miss controls of the cache data array, and stalls the pipeline while memory is busy.

Parameters:
ADDR_W, 20, byte address width
OFFSET_W, 4, line offset bits (16-byte line); tag width TAG_W = ADDR_W-OFFSET_W (local)

Ports:
clk_i  in  1  clock
rsn_i  in  1  asynchronous active-low reset
read_req_i  in  1  pipeline load request
read_addr_i  in  ADDR_W  load byte address
write_req_i  in  1  pipeline store request
write_addr_i  in  ADDR_W  store byte address
write_data_i  in  32  store data
rqst_byte_i  in  1  store is a byte access (else word)
mem_ready_i  in  1  memory completion; refill line valid on the data array's memory input in the same cycle
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  1 = write-through store, 0 = line refill
mem_addr_o  out  ADDR_W  memory address (refill: line aligned, offset 0)
mem_wdata_o  out  32  store data to memory
mem_byte_o  out  1  store is a byte access
read_hit_o  out  1  load hits
read_hit_way_o  out  2  way matching read_addr_i
write_hit_o  out  1  one-cycle data-array write strobe
write_hit_way_o  out  2  way matching write_addr_i
lru_way_o  out  2  victim way for refill
read_miss_o  out  1  one-cycle refill start pulse to the data array
stall_o  out  1  pipeline stall

Behaviour:
- Reset (async, rsn_i low): state IDLE; all valid bits 0; LRU ages way0..3 = 0,1,2,3; victim reg 0. All outputs are 0 during reset except the combinational LRU output: lru_way_o = 0 (first invalid way).
- Hit logic (combinational): compare addr[ADDR_W-1:OFFSET_W] against each valid tag. A hit is a valid match qualified by the request. Hit way = index of the matching way (at most one match). The way output is 0 when there is no hit.
- LRU: one 2-bit age per way, kept as a permutation. On a touch of way w, every way with age < age[w] increments and age[w] becomes 0.
  - Touches: read hit in IDLE with no stall; write hit accepted; refill install.
  - Victim: lowest-index invalid way if any, else the way with age 3.
  - lru_way_o shows the live victim in IDLE and the latched victim in every other state (stable for the whole miss).
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE with write_req_i: go to WR_WAIT. Latch addr/data/byte. write_hit_o = write hit (single cycle). A write miss does not allocate.
  - IDLE with read_req_i, no write_req_i, no hit: read_miss_o = 1 for exactly this cycle. Latch the victim and the line address. Go to RD_WAIT.
  - IDLE with both requests: the write is served first. The load is re-evaluated after the write completes, so the refill sees the updated memory.
  - RD_WAIT: mem_req_o = 1, mem_we_o = 0. On mem_ready_i: write tag and set valid for the victim way, touch it in LRU, go to IDLE. The data array captures the line on that same edge.
  - WR_WAIT: mem_req_o = 1, mem_we_o = 1. On mem_ready_i: go to IDLE.
  - mem_req_o/mem_we_o/mem_addr_o are registered: first asserted the cycle after leaving IDLE, dropped on the cycle after mem_ready_i.
- mem_ready_i in IDLE is ignored.
- stall_o = (state != IDLE) | (IDLE & write_req_i) | (IDLE & read_req_i & !read_hit).
  - Minimum latency: read hit, 0 stall cycles; write, 1 + memory cycles; read miss, 1 + memory cycles + 1 hit cycle.
- Reset mid-transaction abandons it: mem_req_o drops immediately and no tag is installed.

Test Plan:
- Reset, then load 0x00100 -> read_miss_o one pulse, lru_way_o=0, mem_req_o=1/mem_we_o=0/mem_addr_o=0x00100 next cycle. mem_ready_i after 3 cycles -> way0 valid, next cycle read_hit_o=1, read_hit_way_o=0, stall_o=0.
- Fill lines 0x00000, 0x00010, 0x00020, 0x00030, then load 0x00040 -> lru_way_o=0 latched. After re-reading 0x00000 before the miss -> victim=1 instead.
- Store word 0x00014 hitting way1 -> write_hit_o=1 for one cycle, write_hit_way_o=1, mem_we_o=1, mem_addr_o=0x00014, mem_byte_o=0, stall until mem_ready_i. Store to an uncached line -> write_hit_o=0, no allocate.
- Load miss and store in the same IDLE cycle -> store served first (mem_we_o=1), read_miss_o pulses only after WR_WAIT exits.
- Assert rsn_i low during RD_WAIT -> mem_req_o=0 at once, all lines invalid. The same load after reset misses again.
- Hold mem_ready_i high in IDLE with no requests -> no state change, no tag install.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Tag/valid/LRU control for a 4-way data cache with 16-byte lines.
// Arbitrates one memory port between line refills and write-through stores.
module dcache_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int OFFSET_W = 4
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              read_req_i,
    input  logic [ADDR_W-1:0] read_addr_i,
    input  logic              write_req_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [31:0]       write_data_i,
    input  logic              rqst_byte_i,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_byte_o,
    output logic              read_hit_o,
    output logic [1:0]        read_hit_way_o,
    output logic              write_hit_o,
    output logic [1:0]        write_hit_way_o,
    output logic [1:0]        lru_way_o,
    output logic              read_miss_o,
    output logic              stall_o
);

    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int WAYS  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    function automatic logic [1:0] f_first_set(input logic [3:0] vec);
        logic [1:0] idx;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Ages stay a permutation of 0..3: only younger ways than the touched one move.
    function automatic logic [1:0] f_age_next(input logic [1:0] age,
                                              input logic [1:0] touched_age,
                                              input logic       is_touched);
        logic [1:0] nxt;
        if (is_touched) begin
            nxt = 2'd0;
        end else if (age < touched_age) begin
            nxt = age + 2'd1;
        end else begin
            nxt = age;
        end
        return nxt;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TAG_W-1:0]  r_tag [WAYS];
    logic [WAYS-1:0]   r_valid;
    logic [1:0]        r_age [WAYS];
    logic [1:0]        r_victim;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_mem_byte;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic [WAYS-1:0]   w_rd_match;
    logic [WAYS-1:0]   w_wr_match;
    logic [WAYS-1:0]   w_age_max;
    logic              w_rd_hit;
    logic              w_wr_hit;
    logic              w_idle;
    logic [1:0]        w_rd_way;
    logic [1:0]        w_wr_way;
    logic [1:0]        w_live_victim;
    logic              w_wr_accept;
    logic              w_read_miss;
    logic              w_write_hit;
    logic              w_install;
    logic              w_touch;
    logic [1:0]        w_touch_way;
    logic              w_unused_rd_offset;

    assign w_unused_rd_offset = ^read_addr_i[OFFSET_W-1:0];

    // Per-way tag compare and oldest-way detect
    always_comb begin
        w_rd_match = {WAYS{1'b0}};
        w_wr_match = {WAYS{1'b0}};
        w_age_max  = {WAYS{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            w_rd_match[i] = r_valid[i] && (r_tag[i] == read_addr_i[ADDR_W-1:OFFSET_W]);
            w_wr_match[i] = r_valid[i] && (r_tag[i] == write_addr_i[ADDR_W-1:OFFSET_W]);
            w_age_max[i]  = (r_age[i] == 2'd3);
        end
    end

    // Hit qualification, hit way encode and live victim choice
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_rd_hit = read_req_i & (|w_rd_match);
        w_wr_hit = write_req_i & (|w_wr_match);
        if (w_rd_hit) begin
            w_rd_way = f_first_set(w_rd_match);
        end else begin
            w_rd_way = 2'd0;
        end
        if (w_wr_hit) begin
            w_wr_way = f_first_set(w_wr_match);
        end else begin
            w_wr_way = 2'd0;
        end
        if (&r_valid) begin
            w_live_victim = f_first_set(w_age_max);
        end else begin
            w_live_victim = f_first_set(~r_valid);
        end
    end

    // Next state, one-cycle strobes and the LRU touch request
    always_comb begin
        w_state_nxt = r_state;
        w_wr_accept = 1'b0;
        w_read_miss = 1'b0;
        w_write_hit = 1'b0;
        w_install   = 1'b0;
        w_touch     = 1'b0;
        w_touch_way = 2'd0;
        case (r_state)
            IDLE: begin
                // A pending store always wins; the load is re-examined afterwards.
                if (write_req_i) begin
                    w_state_nxt = WR_WAIT;
                    w_wr_accept = 1'b1;
                    w_write_hit = w_wr_hit;
                    w_touch     = w_wr_hit;
                    w_touch_way = w_wr_way;
                end else if (read_req_i) begin
                    if (w_rd_hit) begin
                        w_state_nxt = IDLE;
                        w_touch     = 1'b1;
                        w_touch_way = w_rd_way;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_read_miss = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (mem_ready_i) begin
                    w_state_nxt = IDLE;
                    w_install   = 1'b1;
                    w_touch     = 1'b1;
                    w_touch_way = r_victim;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_ready_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WR_WAIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag/valid array, written only when a refill completes
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i] <= {TAG_W{1'b0}};
            end
            r_valid <= {WAYS{1'b0}};
        end else if (w_install) begin
            r_tag[r_victim]   <= r_mem_addr[ADDR_W-1:OFFSET_W];
            r_valid[r_victim] <= 1'b1;
        end
    end

    // True-LRU ages
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < WAYS; i++) begin
                r_age[i] <= 2'(i);
            end
        end else if (w_touch) begin
            for (int i = 0; i < WAYS; i++) begin
                r_age[i] <= f_age_next(r_age[i], r_age[w_touch_way], (w_touch_way == 2'(i)));
            end
        end
    end

    // Victim frozen for the whole refill
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_victim <= 2'd0;
        end else if (w_read_miss) begin
            r_victim <= w_live_victim;
        end
    end

    // Registered memory port; the held address also supplies the refill tag
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= 32'd0;
        end else if (w_wr_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_byte  <= rqst_byte_i;
            r_mem_addr  <= write_addr_i;
            r_mem_wdata <= write_data_i;
        end else if (w_read_miss) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_byte  <= 1'b0;
            r_mem_addr  <= {read_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_mem_wdata <= 32'd0;
        end else if (!w_idle && mem_ready_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    assign mem_req_o       = r_mem_req;
    assign mem_we_o        = r_mem_we;
    assign mem_addr_o      = r_mem_addr;
    assign mem_wdata_o     = r_mem_wdata;
    assign mem_byte_o      = r_mem_byte;
    assign read_hit_o      = w_rd_hit;
    assign read_hit_way_o  = w_rd_way;
    assign write_hit_o     = w_write_hit;
    assign write_hit_way_o = w_wr_way;
    assign lru_way_o       = w_idle ? w_live_victim : r_victim;
    assign read_miss_o     = w_read_miss;
    assign stall_o         = ~w_idle | w_wr_accept | (w_idle & read_req_i & ~w_rd_hit);

endmodule
